cube_logic_f: RTL and testbench

//  Rubik's-cube state engine: holds colours of all 54 stickers (6 faces x 9) and applies quarter-turn

---
 rtl/cube_logic_f_if.sv | 21 ++
 rtl/cube_logic_f.sv | 166 ++++++++++++++++
 tb/tb_cube_logic_f.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cube_logic_f_if.sv
// cube_logic_f_if: board-side signal bundle for the cube state engine.
//   SW     : SW[2:0] face select, SW[3] direction (0=CW, 1=CCW)
//   KEY    : move button, active-low
//   f1..f6 : front, back, left, right, top, bottom faces;
//            sticker i at bits [3i+2:3i]
//   redraw : one-cycle pulse after each cube state change
// master drives SW/KEY (board/bench); slave is the cube engine.
interface cube_logic_f_if;
  logic [3:0]  SW;
  logic        KEY;
  logic [26:0] f1;
  logic [26:0] f2;
  logic [26:0] f3;
  logic [26:0] f4;
  logic [26:0] f5;
  logic [26:0] f6;
  logic        redraw;

  modport master (output SW, KEY, input f1, f2, f3, f4, f5, f6, redraw);
  modport slave  (input SW, KEY, output f1, f2, f3, f4, f5, f6, redraw);
endinterface

// File: rtl/cube_logic_f.sv
// cube_logic_f: Rubik's-cube state engine. Holds 54 sticker colours and
// applies quarter turns selected on SW when the move button is pressed.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous active-high reset (cube returns to solved)
//   bus      : slave side of cube_logic_f_if (SW, KEY in; f1..f6, redraw out)
// A CCW move is executed as three CW turns on consecutive cycles.
module cube_logic_f (
  input  logic           CLOCK_50,
  input  logic           reset,
  cube_logic_f_if.slave  bus
);

  typedef logic [5:0][8:0][2:0] cube_t;
  typedef enum logic [0:0] {S_IDLE, S_TURN} state_t;

  localparam logic [2:0] FC = 3'd0;
  localparam logic [2:0] BC = 3'd1;
  localparam logic [2:0] LC = 3'd2;
  localparam logic [2:0] RC = 3'd3;
  localparam logic [2:0] UC = 3'd4;
  localparam logic [2:0] DC = 3'd5;

  function automatic cube_t solved_cube();
    cube_t c;
    for (int unsigned f = 0; f < 6; f++)
      for (int unsigned i = 0; i < 9; i++)
        c[f][i] = f[2:0];
    return c;
  endfunction

  // Copy one 3-sticker strip from snapshot s into c.
  function automatic cube_t mv(input cube_t c, input cube_t s,
                               input logic [2:0] df, input logic [3:0] d0, d1, d2,
                               input logic [2:0] sf, input logic [3:0] s0, s1, s2);
    cube_t r;
    r = c;
    r[df][d0] = s[sf][s0];
    r[df][d1] = s[sf][s1];
    r[df][d2] = s[sf][s2];
    return r;
  endfunction

  // One clockwise quarter turn; every read comes from the old snapshot s.
  function automatic cube_t turn_cw(input cube_t s, input logic [2:0] f);
    cube_t n;
    n = s;
    if (f < 3'd6) begin
      n[f][0] = s[f][6]; n[f][1] = s[f][3]; n[f][2] = s[f][0];
      n[f][3] = s[f][7]; n[f][4] = s[f][4]; n[f][5] = s[f][1];
      n[f][6] = s[f][8]; n[f][7] = s[f][5]; n[f][8] = s[f][2];
    end
    case (f)
      FC: begin
        n = mv(n, s, RC, 4'd0, 4'd3, 4'd6, UC, 4'd6, 4'd7, 4'd8);
        n = mv(n, s, DC, 4'd2, 4'd1, 4'd0, RC, 4'd0, 4'd3, 4'd6);
        n = mv(n, s, LC, 4'd2, 4'd5, 4'd8, DC, 4'd0, 4'd1, 4'd2);
        n = mv(n, s, UC, 4'd8, 4'd7, 4'd6, LC, 4'd2, 4'd5, 4'd8);
      end
      BC: begin
        n = mv(n, s, LC, 4'd6, 4'd3, 4'd0, UC, 4'd0, 4'd1, 4'd2);
        n = mv(n, s, DC, 4'd6, 4'd7, 4'd8, LC, 4'd0, 4'd3, 4'd6);
        n = mv(n, s, RC, 4'd8, 4'd5, 4'd2, DC, 4'd6, 4'd7, 4'd8);
        n = mv(n, s, UC, 4'd0, 4'd1, 4'd2, RC, 4'd2, 4'd5, 4'd8);
      end
      LC: begin
        n = mv(n, s, FC, 4'd0, 4'd3, 4'd6, UC, 4'd0, 4'd3, 4'd6);
        n = mv(n, s, DC, 4'd0, 4'd3, 4'd6, FC, 4'd0, 4'd3, 4'd6);
        n = mv(n, s, BC, 4'd8, 4'd5, 4'd2, DC, 4'd0, 4'd3, 4'd6);
        n = mv(n, s, UC, 4'd0, 4'd3, 4'd6, BC, 4'd2, 4'd5, 4'd8);
      end
      RC: begin
        n = mv(n, s, UC, 4'd2, 4'd5, 4'd8, FC, 4'd2, 4'd5, 4'd8);
        n = mv(n, s, BC, 4'd6, 4'd3, 4'd0, UC, 4'd2, 4'd5, 4'd8);
        n = mv(n, s, DC, 4'd2, 4'd5, 4'd8, BC, 4'd6, 4'd3, 4'd0);
        n = mv(n, s, FC, 4'd2, 4'd5, 4'd8, DC, 4'd2, 4'd5, 4'd8);
      end
      UC: begin
        n = mv(n, s, LC, 4'd0, 4'd1, 4'd2, FC, 4'd0, 4'd1, 4'd2);
        n = mv(n, s, BC, 4'd0, 4'd1, 4'd2, LC, 4'd0, 4'd1, 4'd2);
        n = mv(n, s, RC, 4'd0, 4'd1, 4'd2, BC, 4'd0, 4'd1, 4'd2);
        n = mv(n, s, FC, 4'd0, 4'd1, 4'd2, RC, 4'd0, 4'd1, 4'd2);
      end
      DC: begin
        n = mv(n, s, RC, 4'd6, 4'd7, 4'd8, FC, 4'd6, 4'd7, 4'd8);
        n = mv(n, s, BC, 4'd6, 4'd7, 4'd8, RC, 4'd6, 4'd7, 4'd8);
        n = mv(n, s, LC, 4'd6, 4'd7, 4'd8, BC, 4'd6, 4'd7, 4'd8);
        n = mv(n, s, FC, 4'd6, 4'd7, 4'd8, LC, 4'd6, 4'd7, 4'd8);
      end
      default: ;
    endcase
    return n;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  cube_t      r_cube;
  logic       r_key_prev;
  logic       r_ccw;
  logic [2:0] r_face_sel;
  logic [1:0] r_cnt;
  logic       r_redraw;
  logic       r_rst_flag;

  logic w_req;
  logic w_start;
  logic w_apply;
  logic w_last;

  assign w_req   = r_key_prev & ~bus.KEY;
  assign w_start = (r_state == S_IDLE) && w_req && (bus.SW[2:0] < 3'd6);

  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_TURN;
      S_TURN: begin
        w_apply = 1'b1;
        w_last  = ~r_ccw || (r_cnt == 2'd2);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cube     <= solved_cube();
      r_key_prev <= 1'b1;
      r_ccw      <= 1'b0;
      r_face_sel <= '0;
      r_cnt      <= '0;
      r_redraw   <= 1'b0;
      r_rst_flag <= 1'b1;
    end else begin
      r_key_prev <= bus.KEY;
      r_rst_flag <= 1'b0;
      // The first clean edge after reset also counts as a state change.
      r_redraw   <= r_rst_flag | (w_apply & w_last);
      if (w_start) begin
        r_face_sel <= bus.SW[2:0];
        r_ccw      <= bus.SW[3];
        r_cnt      <= '0;
      end
      if (w_apply) begin
        r_cube <= turn_cw(r_cube, r_face_sel);
        r_cnt  <= r_cnt + 2'd1;
      end
    end
  end

  assign bus.f1     = r_cube[FC];
  assign bus.f2     = r_cube[BC];
  assign bus.f3     = r_cube[LC];
  assign bus.f4     = r_cube[RC];
  assign bus.f5     = r_cube[UC];
  assign bus.f6     = r_cube[DC];
  assign bus.redraw = r_redraw;

endmodule

// File: tb/tb_cube_logic_f.sv
// tb_cube_logic_f: directed bench for cube_logic_f with hand-computed faces.
module tb_cube_logic_f;

  typedef logic [5:0][26:0] faces_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cube_logic_f_if bus ();

  cube_logic_f dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned pulses  = 0;

  always @(negedge clk) if (bus.redraw === 1'b1) pulses++;

  function automatic logic [26:0] fv(input logic [2:0] a0, a1, a2, a3, a4,
                                     a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic faces_t solved();
    faces_t e;
    for (int f = 0; f < 6; f++) e[f] = {9{f[2:0]}};
    return e;
  endfunction

  function automatic faces_t obs();
    return {bus.f6, bus.f5, bus.f4, bus.f3, bus.f2, bus.f1};
  endfunction

  function automatic int count_colour(input logic [2:0] c);
    faces_t o;
    int n;
    o = obs();
    n = 0;
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 9; i++)
        if (o[f][3*i +: 3] === c) n++;
    return n;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] sw);
    bus.SW  = sw;
    bus.KEY = 1'b0;
    @(negedge clk);
    bus.KEY = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(3);
  endtask

  task automatic test_reset();
    faces_t o, e;
    int unsigned p0;
    rst = 1'b1; bus.KEY = 1'b1; bus.SW = 4'b0000;
    cyc(3);
    n_tests++;
    if (bus.redraw !== 1'b0) begin
      n_fail++; $display("FAIL reset_redraw: got %b want 0", bus.redraw);
    end
    p0 = pulses;
    rst = 1'b0;
    cyc(5);
    n_tests++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL reset_pulse: got %0d pulses want 1", pulses - p0);
    end
    n_tests++;
    if (bus.redraw !== 1'b0) begin
      n_fail++; $display("FAIL reset_redraw_low: got %b want 0", bus.redraw);
    end
    o = obs(); e = solved();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL reset_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
  endtask

  task automatic test_front_cw();
    faces_t o, e;
    int unsigned p0;
    p0 = pulses;
    press(4'b0000);
    cyc(4);
    e    = solved();
    e[2] = fv(2, 2, 5, 2, 2, 5, 2, 2, 5);
    e[3] = fv(4, 3, 3, 4, 3, 3, 4, 3, 3);
    e[4] = fv(4, 4, 4, 4, 4, 4, 2, 2, 2);
    e[5] = fv(3, 3, 3, 5, 5, 5, 5, 5, 5);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL front_cw_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    n_tests++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL front_cw_pulse: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_right_after_front();
    faces_t o, e;
    int unsigned p0;
    p0 = pulses;
    press(4'b0011);
    cyc(4);
    e[0] = fv(0, 0, 3, 0, 0, 5, 0, 0, 5);
    e[1] = fv(2, 1, 1, 4, 1, 1, 4, 1, 1);
    e[2] = fv(2, 2, 5, 2, 2, 5, 2, 2, 5);
    e[3] = fv(4, 4, 4, 3, 3, 3, 3, 3, 3);
    e[4] = fv(4, 4, 0, 4, 4, 0, 2, 2, 0);
    e[5] = fv(3, 3, 1, 5, 5, 1, 5, 5, 1);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL right_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (count_colour(c[2:0]) != 9) begin
        n_fail++; $display("FAIL colour_count%0d: got %0d want 9", c, count_colour(c[2:0]));
      end
    end
    n_tests++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL right_pulse: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_up_cw();
    faces_t o, e;
    do_reset();
    press(4'b0100);
    cyc(4);
    e    = solved();
    e[0] = fv(3, 3, 3, 0, 0, 0, 0, 0, 0);
    e[1] = fv(2, 2, 2, 1, 1, 1, 1, 1, 1);
    e[2] = fv(0, 0, 0, 2, 2, 2, 2, 2, 2);
    e[3] = fv(1, 1, 1, 3, 3, 3, 3, 3, 3);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL up_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
  endtask

  task automatic test_ccw_inverse();
    faces_t o, e;
    int unsigned p0;
    do_reset();
    p0 = pulses;
    bus.SW = 4'b1000; bus.KEY = 1'b0;
    @(negedge clk);
    bus.KEY = 1'b1;
    @(negedge clk);
    // second press lands while the CCW sequence is still turning
    bus.SW = 4'b0001; bus.KEY = 1'b0;
    @(negedge clk);
    bus.KEY = 1'b1;
    cyc(5);
    e    = solved();
    e[2] = fv(2, 2, 4, 2, 2, 4, 2, 2, 4);
    e[3] = fv(5, 3, 3, 5, 3, 3, 5, 3, 3);
    e[4] = fv(4, 4, 4, 4, 4, 4, 3, 3, 3);
    e[5] = fv(2, 2, 2, 5, 5, 5, 5, 5, 5);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL ccw_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    n_tests++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL ccw_pulse: got %0d want 1", pulses - p0);
    end
    press(4'b0000);
    cyc(4);
    o = obs(); e = solved();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL ccw_undo_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
  endtask

  task automatic test_hold_and_invalid();
    faces_t o, e;
    int unsigned p0;
    do_reset();
    p0 = pulses;
    bus.SW = 4'b0000; bus.KEY = 1'b0;
    cyc(20);
    bus.KEY = 1'b1;
    cyc(3);
    e    = solved();
    e[2] = fv(2, 2, 5, 2, 2, 5, 2, 2, 5);
    e[3] = fv(4, 3, 3, 4, 3, 3, 4, 3, 3);
    e[4] = fv(4, 4, 4, 4, 4, 4, 2, 2, 2);
    e[5] = fv(3, 3, 3, 5, 5, 5, 5, 5, 5);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL hold_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    n_tests++;
    if (pulses - p0 != 1) begin
      n_fail++; $display("FAIL hold_pulse: got %0d want 1", pulses - p0);
    end
    p0 = pulses;
    press(4'b0110);
    cyc(4);
    press(4'b1111);
    cyc(4);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL invalid_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    n_tests++;
    if (pulses != p0) begin
      n_fail++; $display("FAIL invalid_pulse: got %0d want 0", pulses - p0);
    end
  endtask

  task automatic test_reset_mid_ccw();
    faces_t o, e;
    bus.SW = 4'b1000; bus.KEY = 1'b0;
    @(negedge clk);
    bus.KEY = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    e = solved();
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL midccw_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
    rst = 1'b0;
    cyc(5);
    o = obs();
    for (int f = 0; f < 6; f++) begin
      n_tests++;
      if (o[f] !== e[f]) begin
        n_fail++; $display("FAIL midccw_after_face%0d: got %h want %h", f, o[f], e[f]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.KEY = 1'b1; bus.SW = 4'b0000;
    test_reset();
    test_front_cw();
    test_right_after_front();
    test_up_cw();
    test_ccw_inverse();
    test_hold_and_invalid();
    test_reset_mid_ccw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
